// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV64M multiply/divide execute unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL,
    F3_MULH,
    F3_MULHSU,
    F3_MULHU,
    F3_DIV,
    F3_DIVU,
    F3_REM,
    F3_REMU
  } func3_e;

  // Width of a counter that can hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// Word mode pre-shifts the 32-bit dividend to the top so 32 steps suffice.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            run,
  input  logic            word,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem
);

  localparam int CW = cnt_width(XLEN);

  logic [XLEN-1:0] q_r, r_r, d_r;
  logic [CW-1:0]   cnt, limit;
  logic            word_r;
  logic [XLEN:0]   sh, diff;
  logic            ge;

  assign sh    = {r_r, q_r[XLEN-1]};
  assign diff  = sh - {1'b0, d_r};
  assign ge    = !diff[XLEN];
  assign limit = word_r ? CW'(31) : CW'(XLEN - 1);
  assign done  = run && (cnt == limit);

  // Step results are exposed so the caller can capture the final values on the done edge.
  assign rem  = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
  assign quot = {q_r[XLEN-2:0], ge};

  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= '0;
      r_r    <= '0;
      d_r    <= '0;
      cnt    <= '0;
      word_r <= 1'b0;
    end else if (start) begin
      q_r    <= word ? {dividend[31:0], {(XLEN-32){1'b0}}} : dividend;
      r_r    <= '0;
      d_r    <= divisor;
      cnt    <= '0;
      word_r <= word;
    end else if (run) begin
      q_r <= quot;
      r_r <= rem;
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV64M execute unit: decode, 1-cycle multiply, iterative divide with sign fixup.
// MULDIV_DIV_FASTPATH_EN retires divide-by-zero and signed overflow on the accept edge.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN            = 64,
  parameter int ALU_OP_WIDTH    = 7,
  parameter int ALU_FUNC3_WIDTH = 3,
  parameter int ALU_FUNC7_WIDTH = 7,
  parameter int REG_ADDR_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op,
  input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3,
  input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7,
  input  logic [XLEN-1:0]            rs1_val,
  input  logic [XLEN-1:0]            rs2_val,
  input  logic [REG_ADDR_WIDTH-1:0]  rd_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            result,
  output logic [REG_ADDR_WIDTH-1:0]  rd_out,
  output logic                       busy
);

  state_e state, state_nxt;
  func3_e f3_in, f3_q;

  logic            is_md, word_in, accept, sa, sb, neg_a, neg_b, is_div_in;
  logic            div_zero, ovf, special_in, fast, div_start, div_done;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, most_neg, spec_res_in, res_nxt;

  logic            word_q, neg_q_q, neg_r_q, spec_q;
  logic [XLEN-1:0] op_a, op_b, spec_res_q;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  assign f3_in   = func3_e'(alu_func3);
  assign word_in = (alu_op == ALU_OP_WIDTH'(OPC_OP32));
  assign is_md   = (alu_func7 == ALU_FUNC7_WIDTH'(FUNC7_MULDIV)) &&
                   ((alu_op == ALU_OP_WIDTH'(OPC_OP)) || word_in);
  assign accept  = in_valid && in_ready && is_md && !flush;

  assign sa        = f3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign sb        = f3_in inside {F3_MULH, F3_DIV, F3_REM};
  assign is_div_in = alu_func3[2];

  assign a_ext = word_in ? {{(XLEN-32){sa & rs1_val[31]}}, rs1_val[31:0]} : rs1_val;
  assign b_ext = word_in ? {{(XLEN-32){sb & rs2_val[31]}}, rs2_val[31:0]} : rs2_val;
  assign neg_a = sa & a_ext[XLEN-1];
  assign neg_b = sb & b_ext[XLEN-1];
  assign mag_a = neg_a ? -a_ext : a_ext;
  assign mag_b = neg_b ? -b_ext : b_ext;

  // Divide-by-zero and overflow results are resolved up front, independent of the iteration.
  assign most_neg   = word_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero   = (b_ext == '0);
  assign ovf        = sa && (a_ext == most_neg) && (b_ext == '1);
  assign special_in = is_div_in && (div_zero || ovf);

  always_comb begin
    spec_res_in = '1;
    if (div_zero) begin
      if (alu_func3[1])
        spec_res_in = word_in ? {{(XLEN-32){rs1_val[31]}}, rs1_val[31:0]} : rs1_val;
    end else begin
      spec_res_in = alu_func3[1] ? '0 : a_ext;
    end
  end

`ifdef MULDIV_DIV_FASTPATH_EN
  assign fast = special_in;
`else
  assign fast = 1'b0;
`endif

  assign div_start = accept && is_div_in && !fast;

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .run      (state == ST_DIV),
    .word     (word_in),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quot     (),
    .rem      ()
  );

  logic [XLEN-1:0] quot, rem;
  assign quot = u_div.quot;
  assign rem  = u_div.rem;

  logic              ma_s, mb_s;
  logic [2*XLEN-1:0] a_x, b_x, prod;
  logic [XLEN-1:0]   mul_res, q_fix, r_fix, sel, div_res;

  assign ma_s = f3_q inside {F3_MULH, F3_MULHSU};
  assign mb_s = (f3_q == F3_MULH);
  assign a_x  = {{XLEN{ma_s & op_a[XLEN-1]}}, op_a};
  assign b_x  = {{XLEN{mb_s & op_b[XLEN-1]}}, op_b};
  assign prod = a_x * b_x;

  always_comb begin
    mul_res = prod[2*XLEN-1:XLEN];
    if (f3_q == F3_MUL)
      mul_res = word_q ? {{(XLEN-32){prod[31]}}, prod[31:0]} : prod[XLEN-1:0];
  end

  assign q_fix   = neg_q_q ? -quot : quot;
  assign r_fix   = neg_r_q ? -rem : rem;
  assign sel     = (f3_q inside {F3_REM, F3_REMU}) ? r_fix : q_fix;
  assign div_res = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;

  always_comb begin
    res_nxt = result;
    case (state)
      ST_IDLE: res_nxt = spec_res_in;
      ST_MUL:  res_nxt = mul_res;
      ST_DIV:  res_nxt = spec_q ? spec_res_q : div_res;
      default: res_nxt = result;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = fast ? ST_DONE : (is_div_in ? ST_DIV : ST_MUL);
      ST_MUL:  state_nxt = ST_DONE;
      ST_DIV:  if (div_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      result     <= '0;
      rd_out     <= '0;
      f3_q       <= F3_MUL;
      word_q     <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3_q       <= f3_in;
        word_q     <= word_in;
        neg_q_q    <= neg_a ^ neg_b;
        neg_r_q    <= neg_a;
        spec_q     <= special_in;
        spec_res_q <= spec_res_in;
        op_a       <= a_ext;
        op_b       <= b_ext;
        rd_out     <= rd_in;
      end
      // Result is captured only on entry to DONE, so it holds through backpressure.
      if (state_nxt == ST_DONE && state != ST_DONE)
        result <= res_nxt;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit with hand-computed expectations.
module tb_ex_muldiv_unit;

  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] OP32 = 7'b0111011;
`ifdef MULDIV_DIV_FASTPATH_EN
  localparam int LAT_SP64 = 1;
  localparam int LAT_SP32 = 1;
`else
  localparam int LAT_SP64 = 65;
  localparam int LAT_SP32 = 33;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [6:0]  alu_op, alu_func7;
  logic [2:0]  alu_func3;
  logic [63:0] rs1_val, rs2_val, result;
  logic [4:0]  rd_in, rd_out;

  int checks = 0;
  int fails  = 0;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_func3(alu_func3), .alu_func7(alu_func7),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    int g = 0;
    while (in_ready !== 1'b1 && g < 200) begin tick(); g++; end
    in_valid = 1'b1; alu_op = op; alu_func3 = f3; alu_func7 = 7'b0000001;
    rs1_val = a; rs2_val = b; rd_in = rd;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 200) begin tick(); n++; end
  endtask

  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                        input logic [63:0] exp, input int lat);
    int n;
    issue(op, f3, a, b, rd);
    wait_valid(n);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_rd"}, 64'(rd_out), 64'(rd));
    tick();
  endtask

  initial begin
    int n, bad;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; alu_func3 = '0; alu_func7 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 0);
    check("rst_result", result, 0);
    check("rst_rd", 64'(rd_out), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_ready", 64'(in_ready), 1);

    // Non-M op on OP opcode is ignored
    in_valid = 1'b1; alu_op = OP; alu_func3 = 3'd0; alu_func7 = 7'b0000000;
    rs1_val = 64'd1; rs2_val = 64'd2; rd_in = 5'd1;
    tick();
    in_valid = 1'b0;
    check("nonmd_busy", 64'(busy), 0);

    run_op("mul",    OP, 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 2);
    run_op("mulhu",  OP, 3'd3, '1, '1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 2);
    run_op("mulhsu", OP, 3'd2, '1, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_op("mulw",   OP32, 3'd0, 64'h0000_0001_0001_0000, 64'h0000_0000_0001_0000, 5'd4, 64'd0, 2);

    // DIV -20/6 with per-edge busy/in_ready tracking
    issue(OP, 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd8);
    bad = 0;
    for (int e = 1; e <= 64; e++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      tick();
    end
    check("div_busy", 64'(bad), 0);
    check("div_valid65", 64'(out_valid), 1);
    check("div_res", result, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_rd", 64'(rd_out), 64'd8);
    tick();

    run_op("rem",    OP,   3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("divuw",  OP32, 3'd5, 64'hABCD_0000_0000_0064, 64'd7, 5'd10, 64'd14, 33);
    run_op("divw",   OP32, 3'd4, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    run_op("remw",   OP32, 3'd6, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd12, '1, 33);
    run_op("divw_ovf", OP32, 3'd4, 64'h0000_0001_8000_0000, '1, 5'd13, 64'hFFFF_FFFF_8000_0000, LAT_SP32);
    run_op("div_ovf",  OP,   3'd4, 64'h8000_0000_0000_0000, '1, 5'd14, 64'h8000_0000_0000_0000, LAT_SP64);
    run_op("rem_ovf",  OP,   3'd6, 64'h8000_0000_0000_0000, '1, 5'd15, 64'd0, LAT_SP64);
    run_op("remu_z",   OP,   3'd7, 64'h1234, 64'd0, 5'd16, 64'h1234, LAT_SP64);
    run_op("divu_z",   OP,   3'd5, 64'h55, 64'd0, 5'd17, '1, LAT_SP64);
    run_op("remuw_z",  OP32, 3'd7, 64'h0000_0000_8000_0001, 64'h1_0000_0000, 5'd18,
           64'hFFFF_FFFF_8000_0001, LAT_SP32);

    // Backpressure: DONE holds result/rd and refuses a new op
    out_ready = 1'b0;
    issue(OP, 3'd0, 64'd3, 64'd4, 5'd9);
    wait_valid(n);
    check("bp_lat", 64'(n), 2);
    in_valid = 1'b1; alu_op = OP; alu_func3 = 3'd0; alu_func7 = 7'b0000001;
    rs1_val = 64'd5; rs2_val = 64'd5; rd_in = 5'd12;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (result !== 64'd12 || rd_out !== 5'd9 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    check("bp_stable", 64'(bad), 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(out_valid), 0);
    check("bp_release_ready", 64'(in_ready), 1);
    run_op("bp_next", OP, 3'd0, 64'd5, 64'd6, 5'd10, 64'd30, 2);

    // Flush in the same cycle as an accept discards it
    in_valid = 1'b1; alu_op = OP; alu_func3 = 3'd0; alu_func7 = 7'b0000001;
    rs1_val = 64'd2; rs2_val = 64'd2; rd_in = 5'd2; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", 64'(busy), 0);

    // Flush at edge 10 of a DIV
    issue(OP, 3'd4, 64'd100, 64'd7, 5'd3);
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 0);
    check("flush_valid", 64'(out_valid), 0);
    check("flush_ready", 64'(in_ready), 1);
    bad = 0;
    repeat (70) begin tick(); if (out_valid !== 1'b0) bad++; end
    check("flush_no_valid", 64'(bad), 0);

    // Reset in the middle of a MUL
    issue(OP, 3'd0, 64'd6, 64'd7, 5'd11);
    reset = 1'b1;
    tick();
    check("rstmid_valid", 64'(out_valid), 0);
    check("rstmid_result", result, 0);
    check("rstmid_rd", 64'(rd_out), 0);
    check("rstmid_busy", 64'(busy), 0);
    check("rstmid_ready", 64'(in_ready), 1);
    reset = 1'b0;
    tick();
    run_op("post_rst", OP, 3'd0, 64'd6, 64'd7, 5'd13, 64'd42, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
